// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//
// Purpose:
//   Reads a burst of 1..16 words from a show-ahead FIFO. Each word is presented
//   on a registered valid/ready output port. The FIFO is never popped while it
//   is empty. If the FIFO stays empty for STALL_MAX consecutive cycles during a
//   burst, the burst is aborted and the sticky stall_err flag is set.
//
// Optional build macro:
//   FIFO_READ_CTRL_GRAY_OUT_EN - out_data is loaded with the binary-to-Gray
//                                 conversion of fifo_data. Timing is the same
//                                 in both builds.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   clear       in   synchronous soft clear; overrides every other event
//   start       in   burst request, sampled in IDLE only
//   burst_len   in   words to read, 0 means 16
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO head word (show-ahead)
//   fifo_rd     out  FIFO pop strobe (combinational)
//   out_data    out  registered output word
//   out_valid   out  out_data valid
//   out_ready   in   downstream accept
//   busy        out  controller not in IDLE
//   done        out  one-cycle pulse at burst completion
//   stall_err   out  sticky stall-abort flag
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
   parameter int DW        = 8,
   parameter int LEN_W     = 5,
   parameter int STALL_MAX = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             start,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             fifo_empty,
   input  logic [DW-1:0]    fifo_data,
   output logic             fifo_rd,
   output logic [DW-1:0]    out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             stall_err
);

   localparam int SC_W = $clog2(STALL_MAX + 1);
   localparam logic [SC_W-1:0]  STALL_LAST = SC_W'(STALL_MAX - 1);
   localparam logic [LEN_W-1:0] LEN_FULL   = LEN_W'(16);
   localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [SC_W-1:0]  stall_cnt;

   function automatic logic [DW-1:0] out_map(input logic [DW-1:0] d);
`ifdef FIFO_READ_CTRL_GRAY_OUT_EN
      return d ^ (d >> 1);
`else
      return d;
`endif
   endfunction

   // Pop only when the output register is free or is being emptied in the
   // same cycle. Clear suppresses the pop so that no word is lost during a
   // soft clear.
   assign fifo_rd = (state == S_READ) & ~fifo_empty & (remaining != '0) &
                    (~out_valid | out_ready) & ~clear;

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         remaining <= '0;
         stall_cnt <= '0;
         stall_err <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (clear) begin
         state     <= S_IDLE;
         remaining <= '0;
         stall_cnt <= '0;
         stall_err <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               stall_cnt <= '0;
               if (start) begin
                  remaining <= (burst_len == '0) ? LEN_FULL : burst_len;
                  stall_err <= 1'b0;
                  state     <= S_READ;
               end
            end
            S_READ: begin
               if (fifo_rd) begin
                  out_data  <= out_map(fifo_data);
                  out_valid <= 1'b1;
                  remaining <= remaining - LEN_ONE;
                  stall_cnt <= '0;
                  if (remaining == LEN_ONE) begin
                     state <= S_DRAIN;
                  end
               end else begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                  end
                  if (fifo_empty) begin
                     // The abort drops any word still waiting downstream.
                     if (stall_cnt == STALL_LAST) begin
                        stall_err <= 1'b1;
                        out_valid <= 1'b0;
                        stall_cnt <= '0;
                        state     <= S_IDLE;
                     end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                     end
                  end
               end
            end
            S_DRAIN: begin
               stall_cnt <= '0;
               if (!out_valid || out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_ctrl
//
// Directed bench for fifo_read_ctrl. A queue models the show-ahead FIFO.
// Expected output words are queued when each burst is loaded. A monitor
// process compares every out_valid/out_ready handshake against that queue.
// -----------------------------------------------------------------------------
module tb_fifo_read_ctrl;

   localparam int DW    = 8;
   localparam int LEN_W = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clear;
   logic             start;
   logic [LEN_W-1:0] burst_len;
   logic             fifo_empty;
   logic [DW-1:0]    fifo_data;
   logic             fifo_rd;
   logic [DW-1:0]    out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic             stall_err;

   fifo_read_ctrl #(.DW(DW), .LEN_W(LEN_W), .STALL_MAX(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .start      (start),
      .burst_len  (burst_len),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd    (fifo_rd),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .stall_err  (stall_err)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];

   int nchk = 0;
   int nerr = 0;
   int pops = 0;
   int done_cnt = 0;
   int cyc = 0;
   int rd_run = 0;
   int rd_run_max = 0;
   int last_hs_cyc = 0;
   int done_cyc = 0;
   int busy_cycles = 0;
   logic tog = 1'b0;
   logic hold_prev = 1'b0;
   logic [DW-1:0] prev_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] model(input logic [DW-1:0] d);
`ifdef FIFO_READ_CTRL_GRAY_OUT_EN
      return d ^ (d >> 1);
`else
      return d;
`endif
   endfunction

   function void refresh();
      fifo_empty = (fq.size() == 0);
      fifo_data  = fifo_empty ? '0 : fq[0];
   endfunction

   // Cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Out_ready toggler for the backpressure test
   initial forever begin
      @(posedge clk);
      #1;
      if (tog) out_ready = ~out_ready;
   end

   // FIFO model: a pop seen before an edge takes effect just after that edge
   initial forever begin
      bit p;
      @(negedge clk);
      p = fifo_rd && rst_n;
      @(posedge clk);
      #1;
      if (p) begin
         if (fq.size() > 0) void'(fq.pop_front());
         pops++;
         refresh();
      end
   end

   // Monitor / scoreboard
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (fifo_rd) check("no_underflow", {31'b0, fifo_empty}, 32'd0);
         rd_run = fifo_rd ? rd_run + 1 : 0;
         if (rd_run > rd_run_max) rd_run_max = rd_run;
         if (busy) busy_cycles++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (hold_prev && out_valid) check("out_data_stable", {24'b0, out_data}, {24'b0, prev_data});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL unexpected_out: got %0h, expected no output", out_data);
            end else begin
               check("out_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
            end
            last_hs_cyc = cyc;
         end
         hold_prev = out_valid && !out_ready && !clear;
         prev_data = out_data;
      end else begin
         hold_prev = 1'b0;
      end
   end

   task automatic load(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         fq.push_back(base + DW'(i));
         exp_q.push_back(model(base + DW'(i)));
      end
      refresh();
   endtask

   task automatic start_burst(input logic [LEN_W-1:0] len);
      @(posedge clk);
      #1;
      burst_len = len;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      check(name, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, d0, b0;
      logic [DW-1:0] g0, g1;
      rst_n = 1'b0;
      clear = 1'b0;
      start = 1'b0;
      burst_len = '0;
      out_ready = 1'b1;
      refresh();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",      {31'b0, busy},      32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_done",      {31'b0, done},      32'd0);
      check("rst_stall_err", {31'b0, stall_err}, 32'd0);
      check("rst_fifo_rd",   {31'b0, fifo_rd},   32'd0);
      check("rst_out_data",  {24'b0, out_data},  32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Burst of 4 with downstream always ready
      p0 = pops; d0 = done_cnt;
      load(8'h01, 4);
      start_burst(5'd4);
      wait_idle(100, "t1_timeout");
      check("t1_pops",      pops - p0,                  32'd4);
      check("t1_rd_run",    rd_run_max,                 32'd4);
      check("t1_done",      done_cnt - d0,              32'd1);
      check("t1_done_lat",  done_cyc - last_hs_cyc,     32'd1);
      check("t1_exp_empty", exp_q.size(),               32'd0);

      // Burst of 3 with out_ready toggling
      p0 = pops; d0 = done_cnt;
      load(8'h30, 3);
      tog = 1'b1;
      start_burst(5'd3);
      wait_idle(100, "t2_timeout");
      tog = 1'b0;
      out_ready = 1'b1;
      check("t2_pops",      pops - p0,     32'd3);
      check("t2_done",      done_cnt - d0, 32'd1);
      check("t2_exp_empty", exp_q.size(),  32'd0);

      // Empty FIFO: stall abort after 64 cycles
      p0 = pops; d0 = done_cnt; b0 = busy_cycles;
      start_burst(5'd2);
      wait_idle(200, "t3_timeout");
      check("t3_stall_err",   {31'b0, stall_err}, 32'd1);
      check("t3_busy_cycles", busy_cycles - b0,   32'd64);
      check("t3_pops",        pops - p0,          32'd0);
      check("t3_no_done",     done_cnt - d0,      32'd0);
      check("t3_out_valid",   {31'b0, out_valid}, 32'd0);
      repeat (5) @(negedge clk);
      check("t3_sticky",      {31'b0, stall_err}, 32'd1);

      // burst_len 0 means 16; a start during the burst is ignored
      p0 = pops; d0 = done_cnt;
      load(8'h10, 16);
      start_burst(5'd0);
      check("t4_err_cleared", {31'b0, stall_err}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      burst_len = 5'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(300, "t4_timeout");
      check("t4_pops",      pops - p0,     32'd16);
      check("t4_done",      done_cnt - d0, 32'd1);
      check("t4_exp_empty", exp_q.size(),  32'd0);

      // Clear after 2 of 8 pops, then reset mid-burst
      p0 = pops; d0 = done_cnt;
      load(8'hA0, 8);
      start_burst(5'd8);
      @(posedge clk);
      @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
      check("t5_pops",      pops - p0,          32'd2);
      check("t5_out_valid", {31'b0, out_valid}, 32'd0);
      check("t5_busy",      {31'b0, busy},      32'd0);
      check("t5_exp_left",  exp_q.size(),       32'd6);
      exp_q.delete();
      foreach (fq[i]) exp_q.push_back(model(fq[i]));
      start_burst(5'd6);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy",      {31'b0, busy},      32'd0);
      check("t5_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("t5_rst_out_data",  {24'b0, out_data},  32'd0);
      check("t5_rst_fifo_rd",   {31'b0, fifo_rd},   32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      fq.delete();
      refresh();
      repeat (4) @(negedge clk);
      check("t5_idle_after", {31'b0, busy},  32'd0);
      check("t5_no_done",    done_cnt - d0,  32'd0);

      // Output mapping: hand-computed values for each build
`ifdef FIFO_READ_CTRL_GRAY_OUT_EN
      g0 = 8'h07;
      g1 = 8'h80;
`else
      g0 = 8'h05;
      g1 = 8'hFF;
`endif
      d0 = done_cnt;
      fq.push_back(8'h05);
      exp_q.push_back(g0);
      refresh();
      start_burst(5'd1);
      wait_idle(100, "t6a_timeout");
      fq.push_back(8'hFF);
      exp_q.push_back(g1);
      refresh();
      start_burst(5'd1);
      wait_idle(100, "t6b_timeout");
      check("t6_done",      done_cnt - d0, 32'd2);
      check("t6_exp_empty", exp_q.size(),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8: FIFO/output data width.
REQ-002 SHALL have parameter LEN_W, default 5: burst length width, range 1..16.
REQ-003 SHALL have parameter STALL_MAX, default 64: consecutive empty cycles in READ before abort.
REQ-004 SHALL have port clk  input  1: sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous active-low reset.
REQ-006 SHALL have port clear  input  1: synchronous soft clear.
REQ-007 SHALL have port start  input  1: burst request, sampled in IDLE only.
REQ-008 SHALL have port burst_len  input  LEN_W: bytes to read; 0 treated as 16.
REQ-009 SHALL have port fifo_empty  input  1: FIFO empty flag.
REQ-010 SHALL have port fifo_data  input  DW: FIFO head word, combinational, valid while fifo_empty=0.
REQ-011 SHALL have port fifo_rd  output  1: FIFO pop strobe.
REQ-012 SHALL have port out_data  output  DW: registered output byte.
REQ-013 SHALL have port out_valid  output  1: out_data valid.
REQ-014 SHALL have port out_ready  input  1: downstream accept.
REQ-015 SHALL have port busy  output  1: high in any state except IDLE.
REQ-016 SHALL have port done  output  1: one-cycle pulse at burst completion.
REQ-017 SHALL have port stall_err  output  1: sticky abort flag, cleared by next accepted start, clear or reset.

Function
REQ-018 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL load remaining count from burst_len (0->16), clear stall_err, enter READ next cycle.
REQ-020 READ: fifo_rd SHALL equal (~fifo_empty) & (remaining!=0) & (~out_valid | out_ready), combinational.
REQ-021 On each fifo_rd edge: out_data SHALL load fifo_data, out_valid SHALL be 1, remaining SHALL decrement; output latency one cycle after pop.
REQ-022 out_valid SHALL clear on out_ready=1 with no same-cycle pop; a simultaneous pop and accept SHALL keep out_valid=1 with new data (no bubble).
REQ-023 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 READ->DRAIN SHALL occur on the edge where remaining reaches 0.
REQ-025 DRAIN: no pops; DRAIN->DONE when out_valid=0 or out_ready=1.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; start in DONE SHALL be ignored.
REQ-027 Stall counter SHALL increment each READ cycle with fifo_empty=1, reset to 0 on any pop or state entry.
REQ-028 Counter reaching STALL_MAX SHALL set stall_err=1, drop pending out_valid, go IDLE without done pulse.
REQ-029 fifo_rd SHALL never assert with fifo_empty=1 or outside READ (no underflow caused).
REQ-030 start while busy SHALL be ignored.
REQ-031 clear=1 SHALL, at the next edge, force IDLE, out_valid=0, remaining=0, stall counter=0, stall_err=0; clear SHALL override all other events that cycle.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, fifo_rd=0, out_data=0, out_valid=0, busy=0, done=0, stall_err=0, counters=0.
REQ-033 Reset asserted mid-burst SHALL abort with no done pulse; release SHALL resume in IDLE.

Configuration
REQ-034 With macro FIFO_READ_CTRL_GRAY_OUT_EN defined, out_data SHALL load fifo_data ^ (fifo_data >> 1) (binary-to-Gray).
REQ-035 Without FIFO_READ_CTRL_GRAY_OUT_EN, out_data SHALL load fifo_data unchanged; all timing identical in both builds.

Verification
REQ-036 FIFO preloaded 0x01..0x04, burst_len=4, out_ready=1 -> fifo_rd high 4 consecutive cycles, out_data 0x01..0x04 back-to-back, done one pulse after last accept.
REQ-037 burst_len=3, out_ready toggling 1/0 -> exactly 3 pops, no data lost or duplicated, out_data stable during stall.
REQ-038 FIFO empty, burst_len=2, no writes -> fifo_rd never asserts, stall_err=1 after 64 cycles, busy=0, no done.
REQ-039 burst_len=0 with 16 bytes 0x10..0x1F -> 16 pops, done pulse; start during burst ignored.
REQ-040 clear asserted after 2 of 8 pops, then rst_n pulsed mid-burst -> IDLE, out_valid=0, done never pulses.
REQ-041 GRAY_OUT_EN build, fifo_data 0x05 -> out_data 0x07; 0xFF -> 0x80; non-macro build -> 0x05, 0xFF.
